// File: rtl/regfile_writeback_pkg.sv
// Shared types and defaults for the register-file write-back front end.
package regfile_writeback_pkg;
   localparam int WORD          = 8;
   localparam int WB_DATA_W     = 4 * WORD;
   localparam int WB_ADDR_SPACE = 5;
   localparam int WB_FIFO_DEPTH = 2;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } wb_src_e;
endpackage

// File: rtl/regfile_writeback_fifo.sv
// In-order FIFO of {addr, data} beats with a per-entry valid/address view.
module regfile_writeback_fifo
   import regfile_writeback_pkg::*;
#(
   parameter int WIDTH      = WB_DATA_W,
   parameter int ADDR_SPACE = WB_ADDR_SPACE,
   parameter int DEPTH      = WB_FIFO_DEPTH
) (
   input  logic                             i_clk,
   input  logic                             i_rst_n,
   input  logic                             i_push,
   input  logic                             i_pop,
   input  logic [ADDR_SPACE-1:0]            i_addr,
   input  logic [WIDTH-1:0]                 i_data,
   output logic                             o_full,
   output logic                             o_empty,
   output logic [ADDR_SPACE-1:0]            o_head_addr,
   output logic [WIDTH-1:0]                 o_head_data,
   output logic [DEPTH-1:0]                 o_ent_vld,
   output logic [DEPTH-1:0][ADDR_SPACE-1:0] o_ent_addr
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_SPACE-1:0] r_addr [DEPTH];
   logic [WIDTH-1:0]      r_data [DEPTH];
   logic [DEPTH-1:0]      r_vld;
   logic [PW-1:0]         r_rd;
   logic [PW-1:0]         r_wr;
   logic [CW-1:0]         r_cnt;
   logic                  w_push;
   logic                  w_pop;

   assign o_full  = (r_cnt == CW'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vld <= '0;
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_pop) begin
            r_vld[r_rd] <= 1'b0;
            r_rd        <= r_rd + 1'b1;
         end
         if (w_push) begin
            r_vld[r_wr] <= 1'b1;
            r_wr        <= r_wr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_addr[r_wr] <= i_addr;
         r_data[r_wr] <= i_data;
      end
   end

   assign o_head_addr = r_addr[r_rd];
   assign o_head_data = r_data[r_rd];
   assign o_ent_vld   = r_vld;

   always_comb begin
      o_ent_addr = '0;
      for (int i = 0; i < DEPTH; i++) begin
         o_ent_addr[i] = r_addr[i];
      end
   end
endmodule

// File: rtl/regfile_writeback.sv
// Two-source write-back front end: per-source FIFOs, round-robin arbitration
// onto the single register-file write port, and a pending-destination bitmap.
module regfile_writeback
   import regfile_writeback_pkg::*;
#(
   parameter int                    WIDTH         = WB_DATA_W,
   parameter int                    ADDR_SPACE    = WB_ADDR_SPACE,
   parameter logic [ADDR_SPACE-1:0] ZERO_REGISTER = '0,
   parameter int                    FIFO_DEPTH    = WB_FIFO_DEPTH
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_alu_valid,
   output logic                       o_alu_ready,
   input  logic [ADDR_SPACE-1:0]      i_alu_addr,
   input  logic [WIDTH-1:0]           i_alu_data,
   input  logic                       i_mem_valid,
   output logic                       o_mem_ready,
   input  logic [ADDR_SPACE-1:0]      i_mem_addr,
   input  logic [WIDTH-1:0]           i_mem_data,
   output logic                       o_wr_en,
   output logic [ADDR_SPACE-1:0]      o_wr_addr,
   output logic [WIDTH-1:0]           o_wr_data,
   output logic [2**ADDR_SPACE-1:0]   o_pend_mask,
   output logic                       o_busy
);
   localparam int NREG = 2**ADDR_SPACE;

   logic                                  w_alu_full, w_alu_empty, w_mem_full, w_mem_empty;
   logic                                  w_alu_push, w_mem_push, w_gnt_alu, w_gnt_mem;
   logic [ADDR_SPACE-1:0]                 w_alu_head_addr, w_mem_head_addr, w_sel_addr;
   logic [WIDTH-1:0]                      w_alu_head_data, w_mem_head_data, w_sel_data;
   logic [FIFO_DEPTH-1:0]                 w_alu_ent_vld, w_mem_ent_vld;
   logic [FIFO_DEPTH-1:0][ADDR_SPACE-1:0] w_alu_ent_addr, w_mem_ent_addr;
   logic [NREG-1:0]                       w_pend;
   wb_src_e                               r_rr;
   logic                                  r_wr_en;
   logic [ADDR_SPACE-1:0]                 r_wr_addr;
   logic [WIDTH-1:0]                      r_wr_data;

   // Ready depends only on stored occupancy, and is held low during reset.
   assign o_alu_ready = !w_alu_full && i_rst_n;
   assign o_mem_ready = !w_mem_full && i_rst_n;
   assign w_alu_push  = i_alu_valid && o_alu_ready && (i_alu_addr != ZERO_REGISTER);
   assign w_mem_push  = i_mem_valid && o_mem_ready && (i_mem_addr != ZERO_REGISTER);

   regfile_writeback_fifo #(.WIDTH(WIDTH), .ADDR_SPACE(ADDR_SPACE), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_push      (w_alu_push),
      .i_pop       (w_gnt_alu),
      .i_addr      (i_alu_addr),
      .i_data      (i_alu_data),
      .o_full      (w_alu_full),
      .o_empty     (w_alu_empty),
      .o_head_addr (w_alu_head_addr),
      .o_head_data (w_alu_head_data),
      .o_ent_vld   (w_alu_ent_vld),
      .o_ent_addr  (w_alu_ent_addr)
   );

   regfile_writeback_fifo #(.WIDTH(WIDTH), .ADDR_SPACE(ADDR_SPACE), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_push      (w_mem_push),
      .i_pop       (w_gnt_mem),
      .i_addr      (i_mem_addr),
      .i_data      (i_mem_data),
      .o_full      (w_mem_full),
      .o_empty     (w_mem_empty),
      .o_head_addr (w_mem_head_addr),
      .o_head_data (w_mem_head_data),
      .o_ent_vld   (w_mem_ent_vld),
      .o_ent_addr  (w_mem_ent_addr)
   );

   assign w_gnt_alu  = !w_alu_empty && (w_mem_empty || (r_rr == SRC_ALU));
   assign w_gnt_mem  = !w_mem_empty && !w_gnt_alu;
   assign w_sel_addr = w_gnt_alu ? w_alu_head_addr : w_mem_head_addr;
   assign w_sel_data = w_gnt_alu ? w_alu_head_data : w_mem_head_data;

   // Round-robin pointer only moves after a contested grant.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rr      <= SRC_ALU;
         r_wr_en   <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         if (!w_alu_empty && !w_mem_empty) begin
            r_rr <= (r_rr == SRC_ALU) ? SRC_MEM : SRC_ALU;
         end
         r_wr_en <= w_gnt_alu || w_gnt_mem;
         if (w_gnt_alu || w_gnt_mem) begin
            r_wr_addr <= w_sel_addr;
            r_wr_data <= w_sel_data;
         end
      end
   end

   always_comb begin
      w_pend = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (w_alu_ent_vld[i]) w_pend[w_alu_ent_addr[i]] = 1'b1;
         if (w_mem_ent_vld[i]) w_pend[w_mem_ent_addr[i]] = 1'b1;
      end
      if (r_wr_en) w_pend[r_wr_addr] = 1'b1;
      w_pend[ZERO_REGISTER] = 1'b0;
   end

   assign o_pend_mask = w_pend;
   assign o_busy      = !w_alu_empty || !w_mem_empty || r_wr_en;
   assign o_wr_en     = r_wr_en;
   assign o_wr_addr   = r_wr_addr;
   assign o_wr_data   = r_wr_data;
endmodule

// File: tb/tb_regfile_writeback.sv
// Randomised and directed bench for regfile_writeback against a queue-based reference model.
module tb_regfile_writeback;
   import regfile_writeback_pkg::*;

   localparam int W  = WB_DATA_W;
   localparam int A  = WB_ADDR_SPACE;
   localparam int D  = WB_FIFO_DEPTH;
   localparam int NR = 2**A;
   localparam int VW = 1 + A + W + NR + 1;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic          i_alu_valid = 1'b0, i_mem_valid = 1'b0;
   logic [A-1:0]  i_alu_addr = '0, i_mem_addr = '0;
   logic [W-1:0]  i_alu_data = '0, i_mem_data = '0;
   logic          o_alu_ready, o_mem_ready, o_wr_en, o_busy;
   logic [A-1:0]  o_wr_addr;
   logic [W-1:0]  o_wr_data;
   logic [NR-1:0] o_pend_mask;

   int n_checks = 0;
   int n_fail   = 0;

   regfile_writeback dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_alu_valid (i_alu_valid),
      .o_alu_ready (o_alu_ready),
      .i_alu_addr  (i_alu_addr),
      .i_alu_data  (i_alu_data),
      .i_mem_valid (i_mem_valid),
      .o_mem_ready (o_mem_ready),
      .i_mem_addr  (i_mem_addr),
      .i_mem_data  (i_mem_data),
      .o_wr_en     (o_wr_en),
      .o_wr_addr   (o_wr_addr),
      .o_wr_data   (o_wr_data),
      .o_pend_mask (o_pend_mask),
      .o_busy      (o_busy)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: queued beats per source, a fairness bit and the write port.
   typedef struct packed {
      logic [A-1:0] a;
      logic [W-1:0] d;
   } beat_t;

   beat_t        qa[$];
   beat_t        qm[$];
   bit           m_rr;
   bit           m_wr_en;
   logic [A-1:0] m_wr_addr;
   logic [W-1:0] m_wr_data;

   function automatic bit m_ardy();
      return (i_rst_n === 1'b1) && (qa.size() < D);
   endfunction

   function automatic bit m_mrdy();
      return (i_rst_n === 1'b1) && (qm.size() < D);
   endfunction

   function automatic logic [NR-1:0] m_pend();
      logic [NR-1:0] p = '0;
      foreach (qa[i]) p[qa[i].a] = 1'b1;
      foreach (qm[i]) p[qm[i].a] = 1'b1;
      if (m_wr_en) p[m_wr_addr] = 1'b1;
      p[0] = 1'b0;
      return p;
   endfunction

   function automatic logic [VW-1:0] m_vec();
      logic b = (qa.size() != 0) || (qm.size() != 0) || m_wr_en;
      return {m_wr_en, m_wr_addr, m_wr_data, m_pend(), b};
   endfunction

   wire [VW-1:0] dut_vec = {o_wr_en, o_wr_addr, o_wr_data, o_pend_mask, o_busy};

   task automatic model_reset();
      qa.delete();
      qm.delete();
      m_rr      = 1'b0;
      m_wr_en   = 1'b0;
      m_wr_addr = '0;
      m_wr_data = '0;
   endtask

   // One clock: decide acceptance from the model, advance the model at the edge, return at negedge.
   task automatic tick(output bit acc_a, output bit acc_m);
      beat_t b;
      bit ha, hm, g;
      acc_a = i_alu_valid && m_ardy();
      acc_m = i_mem_valid && m_mrdy();
      @(posedge i_clk);
      if (i_rst_n !== 1'b1) begin
         model_reset();
      end else begin
         ha = qa.size() != 0;
         hm = qm.size() != 0;
         if (ha && hm) begin
            g    = m_rr;
            m_rr = !m_rr;
         end else begin
            g = hm;
         end
         if (ha || hm) begin
            b         = g ? qm.pop_front() : qa.pop_front();
            m_wr_en   = 1'b1;
            m_wr_addr = b.a;
            m_wr_data = b.d;
         end else begin
            m_wr_en = 1'b0;
         end
         if (acc_a && i_alu_addr != '0) qa.push_back('{a: i_alu_addr, d: i_alu_data});
         if (acc_m && i_mem_addr != '0) qm.push_back('{a: i_mem_addr, d: i_mem_data});
      end
      @(negedge i_clk);
   endtask

   task automatic idle(input int n);
      bit x, y;
      i_alu_valid = 1'b0;
      i_mem_valid = 1'b0;
      for (int i = 0; i < n; i++) tick(x, y);
   endtask

   task automatic test_reset();
      bit x, y;
      i_rst_n = 1'b0;
      model_reset();
      @(negedge i_clk);
      i_alu_valid = 1'b1;
      i_alu_addr  = A'(3);
      i_alu_data  = 32'h0000_00AB;
      tick(x, y);
      tick(x, y);
      n_checks++;
      if ({o_alu_ready, o_mem_ready} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_ready: got %b required 00", {o_alu_ready, o_mem_ready});
      end
      n_checks++;
      if (dut_vec !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h required 0", dut_vec);
      end
      i_rst_n = 1'b1;
      #1;
      n_checks++;
      if (o_alu_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b required 1", o_alu_ready);
      end
      tick(x, y);
      i_alu_valid = 1'b0;
      n_checks++;
      if (x !== 1'b1 || o_wr_en !== 1'b0 || o_pend_mask !== NR'(32'h8)) begin
         n_fail++;
         $display("FAIL reset_accept: wr_en %b pend %h, required wr_en 0 pend 8", o_wr_en, o_pend_mask);
      end
      tick(x, y);
      n_checks++;
      if (o_wr_en !== 1'b1 || o_wr_addr !== A'(3) || o_wr_data !== 32'h0000_00AB) begin
         n_fail++;
         $display("FAIL reset_first_write: got %b/%0d/%h required 1/3/ab", o_wr_en, o_wr_addr, o_wr_data);
      end
      idle(2);
   endtask

   task automatic test_stream();
      bit x, y;
      int cyc[$];
      logic [A-1:0] got[$];
      for (int c = 0; c < 8; c++) begin
         i_alu_valid = (c < 4);
         i_alu_addr  = A'(c + 1);
         i_alu_data  = W'((c + 1) * 16);
         if (c < 4) begin
            n_checks++;
            if (o_alu_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL stream_ready: cycle %0d got %b required 1", c, o_alu_ready);
            end
         end
         tick(x, y);
         if (o_wr_en === 1'b1) begin
            got.push_back(o_wr_addr);
            cyc.push_back(c);
         end
         n_checks++;
         if (dut_vec !== m_vec()) begin
            n_fail++;
            $display("FAIL stream_vec: cycle %0d got %h required %h", c, dut_vec, m_vec());
         end
      end
      n_checks++;
      if (got.size() != 4) begin
         n_fail++;
         $display("FAIL stream_count: got %0d writes required 4", got.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (got[k] !== A'(k + 1) || cyc[k] != cyc[0] + k) begin
               n_fail++;
               $display("FAIL stream_order: write %0d got addr %0d at cycle %0d required addr %0d at cycle %0d",
                        k, got[k], cyc[k], k + 1, cyc[0] + k);
            end
         end
      end
   endtask

   task automatic test_contention();
      bit x, y;
      logic [A-1:0] got[$];
      logic [A-1:0] exp_order[4] = '{A'(5), A'(7), A'(6), A'(8)};
      for (int c = 0; c < 8; c++) begin
         i_alu_valid = (c < 2);
         i_mem_valid = (c < 2);
         i_alu_addr  = A'(5 + c);
         i_mem_addr  = A'(7 + c);
         i_alu_data  = W'(32'hA000 + c);
         i_mem_data  = W'(32'hB000 + c);
         tick(x, y);
         if (c < 2) begin
            n_checks++;
            if (!(x && y)) begin
               n_fail++;
               $display("FAIL contention_accept: cycle %0d got %b%b required 11", c, x, y);
            end
         end
         if (o_wr_en === 1'b1) got.push_back(o_wr_addr);
      end
      n_checks++;
      if (got.size() != 4) begin
         n_fail++;
         $display("FAIL contention_count: got %0d writes required 4", got.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (got[k] !== exp_order[k]) begin
               n_fail++;
               $display("FAIL contention_order: write %0d got %0d required %0d", k, got[k], exp_order[k]);
            end
         end
      end
      idle(1);
   endtask

   task automatic test_zero_reg();
      bit x, y;
      i_alu_valid = 1'b1;
      i_alu_addr  = '0;
      i_alu_data  = W'(32'hFF);
      n_checks++;
      if (o_alu_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_ready: got %b required 1", o_alu_ready);
      end
      tick(x, y);
      i_alu_valid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         n_checks++;
         if (o_wr_en !== 1'b0 || o_pend_mask !== '0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_reg: wr_en %b pend %h busy %b required 0/0/0", o_wr_en, o_pend_mask, o_busy);
         end
         tick(x, y);
      end
   endtask

   task automatic test_backpressure();
      bit aa, am;
      int na = 0, nm = 0, nw = 0;
      bit saw_low = 0;
      for (int c = 0; c < 12; c++) begin
         i_alu_valid = 1'b1;
         i_mem_valid = 1'b1;
         i_alu_addr  = A'(9 + na % 8);
         i_mem_addr  = A'(17 + nm % 8);
         i_alu_data  = W'($urandom);
         i_mem_data  = W'($urandom);
         n_checks++;
         if ({o_alu_ready, o_mem_ready} !== {m_ardy(), m_mrdy()}) begin
            n_fail++;
            $display("FAIL bp_ready: cycle %0d got %b required %b", c, {o_alu_ready, o_mem_ready}, {m_ardy(), m_mrdy()});
         end
         if (qm.size() == D) saw_low = 1;
         tick(aa, am);
         if (aa) na++;
         if (am) nm++;
         if (o_wr_en === 1'b1) nw++;
         n_checks++;
         if (dut_vec !== m_vec()) begin
            n_fail++;
            $display("FAIL bp_vec: cycle %0d got %h required %h", c, dut_vec, m_vec());
         end
      end
      i_alu_valid = 1'b0;
      i_mem_valid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick(aa, am);
         if (o_wr_en === 1'b1) nw++;
      end
      n_checks++;
      if (!saw_low || nw != na + nm) begin
         n_fail++;
         $display("FAIL bp_total: full_seen %0d writes %0d required full_seen 1 writes %0d", saw_low, nw, na + nm);
      end
   endtask

   task automatic test_random();
      bit aa, am;
      for (int c = 0; c < 400; c++) begin
         i_alu_valid = ($urandom_range(0, 3) != 0);
         i_mem_valid = ($urandom_range(0, 2) != 0);
         i_alu_addr  = ($urandom_range(0, 9) == 0) ? '0 : A'($urandom_range(1, NR - 1));
         i_mem_addr  = ($urandom_range(0, 9) == 0) ? '0 : A'($urandom_range(1, NR - 1));
         i_alu_data  = W'($urandom);
         i_mem_data  = W'($urandom);
         n_checks++;
         if ({o_alu_ready, o_mem_ready} !== {m_ardy(), m_mrdy()}) begin
            n_fail++;
            $display("FAIL rand_ready: cycle %0d got %b required %b", c, {o_alu_ready, o_mem_ready}, {m_ardy(), m_mrdy()});
         end
         tick(aa, am);
         n_checks++;
         if (dut_vec !== m_vec()) begin
            n_fail++;
            $display("FAIL rand_vec: cycle %0d got %h required %h", c, dut_vec, m_vec());
         end
      end
      idle(6);
   endtask

   task automatic test_reset_midflight();
      bit aa, am;
      int na = 0, nm = 0;
      bit reached = 0;
      for (int c = 0; c < 20 && !reached; c++) begin
         i_alu_valid = 1'b1;
         i_mem_valid = 1'b1;
         i_alu_addr  = A'(2 + na % 8);
         i_mem_addr  = A'(20 + nm % 8);
         i_alu_data  = W'($urandom);
         i_mem_data  = W'($urandom);
         tick(aa, am);
         if (aa) na++;
         if (am) nm++;
         reached = (qa.size() + qm.size() >= 3) && m_wr_en;
      end
      n_checks++;
      if (!reached || o_wr_en !== 1'b1 || o_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midflight_setup: reached %0d wr_en %b busy %b required 1/1/1", reached, o_wr_en, o_busy);
      end
      i_rst_n = 1'b0;
      #1;
      n_checks++;
      if (dut_vec !== '0 || {o_alu_ready, o_mem_ready} !== 2'b00) begin
         n_fail++;
         $display("FAIL midflight_async: got %h ready %b required 0 ready 00", dut_vec, {o_alu_ready, o_mem_ready});
      end
      i_alu_valid = 1'b0;
      i_mem_valid = 1'b0;
      tick(aa, am);
      i_rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick(aa, am);
         n_checks++;
         if (o_wr_en !== 1'b0 || o_busy !== 1'b0 || o_pend_mask !== '0) begin
            n_fail++;
            $display("FAIL midflight_after: cycle %0d wr_en %b busy %b pend %h required 0/0/0", c, o_wr_en, o_busy, o_pend_mask);
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_contention();
      test_zero_reg();
      test_backpressure();
      test_random();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side front end for the 32-entry register file. It collects destination-register results from two independent producers, the ALU and the load/memory unit, over valid/ready handshakes. Each source is buffered in a small FIFO, and the two sources share the register file's single write port through round-robin arbitration. The block also exports a pending-destination bitmap that issue logic uses for RAW hazard stalls.

## Interface
- WIDTH, 4*`WORD, data width; must equal the register file's write-data width.
- ADDR_SPACE, 5, register address width.
- ZERO_REGISTER, 5'b00000, hard-wired zero register; writes to it are discarded.
- FIFO_DEPTH, 2, entries per source FIFO; must be a power of two and at least 2.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU FIFO can accept.
- alu_addr  in  ADDR_SPACE  ALU destination register.
- alu_data  in  WIDTH  ALU result.
- mem_valid  in  1  load result offered.
- mem_ready  out  1  MEM FIFO can accept.
- mem_addr  in  ADDR_SPACE  load destination register.
- mem_data  in  WIDTH  load result.
- wr_en  out  1  registered write strobe to the register file.
- wr_addr  out  ADDR_SPACE  registered write address.
- wr_data  out  WIDTH  registered write data.
- pend_mask  out  2**ADDR_SPACE  bit r is set while any write to register r is queued or on the wr_* outputs.
- busy  out  1  OR of both FIFOs non-empty and wr_en.

## Operation
- **Acceptance.** A beat is accepted on the rising edge where valid && ready.
  - ready = (count < FIFO_DEPTH), decoded from registered count only. There is no combinational path from the grant to ready.
  - A full FIFO holds ready low in the cycle it drains. A new beat enters on the following edge.
- **Zero-register beats.** An accepted beat with addr == ZERO_REGISTER completes the handshake but is not enqueued. Count does not change.
- **Source FIFOs.** Each source FIFO is strictly in-order.
  - Enqueue and dequeue on the same edge leave count unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- **Arbiter.** Each cycle, if at least one FIFO head is valid, exactly one source is granted and its head is dequeued.
  - If only one source is non-empty, that source wins.
  - If both are non-empty, the source selected by the round-robin pointer rr wins. After such a contested grant, rr flips to the other source.
  - rr is unchanged on uncontested grants and idle cycles.
- **Output register.** On a grant, wr_en <= 1 and wr_addr/wr_data <= the granted head. With no grant, wr_en <= 0 and wr_addr/wr_data hold their previous values. Every cycle with wr_en=1 is exactly one register-file write.
- **Ordering.** Ordering across sources is defined only by arbitration. Issue logic must not issue a second writer to a register whose pend_mask bit is set.
- **pend_mask.** Decoded combinationally from the valid FIFO entries plus (wr_en ? wr_addr : none). Bit ZERO_REGISTER is always 0.

## Timing
- **Reset values (rst_n low, asynchronous).**
  - Both FIFOs are empty and rr = ALU.
  - wr_en=0, wr_addr=0, wr_data=0.
  - pend_mask=0 and busy=0.
  - alu_ready and mem_ready are forced to 0 while rst_n is low, and rise in the first cycle after deassertion.
- **Latency.**
  - A beat accepted at edge E with an otherwise idle block has wr_en high during cycle E+1..E+2. The register file commits it at edge E+2.
  - pend_mask shows the beat's bit from E until E+2.
- **Throughput.** One write per cycle sustained. Each source alone sustains one beat per cycle with FIFO_DEPTH ≥ 2.
- **Contested cycles.** Under continuous contention, grants alternate ALU, MEM, ALU, and so on.
- **Reset mid-operation.** All queued beats and any wr_en in flight are dropped. Nothing is written after rst_n falls.

## Structure
- specs.vh adds the source indices SRC_ALU=0 and SRC_MEM=1, and the default WB_FIFO_DEPTH.
- One sub-module, wb_fifo: a synchronous FIFO of {addr, data}.
  - Ports: push, pop, full, empty, head, and a per-entry valid/address view for the pend_mask decode.
  - Instantiated twice.
- Arbiter, output register and pend_mask decode live in regfile_writeback.

## Test plan
- **Reset.** Hold rst_n low with alu_valid=1 and addr=3.
  - Required: ready=0, wr_en=0, pend_mask=0.
  - Release reset: the beat is accepted on the first edge, and wr_en=1 with wr_addr=3 on the next cycle.
- **Single-source stream.** ALU offers addrs 1,2,3,4 back-to-back with data 0x10..0x40 and mem idle.
  - Required: four consecutive wr_en cycles, in order, with alu_ready never low.
- **Contention.** Both sources continuously valid: ALU addrs 5,6 and MEM addrs 7,8, all accepted on the same edges.
  - Required: writes appear in the order 5, 7, 6, 8 (rr starts at ALU).
- **Backpressure.** Hold the MEM FIFO non-draining by keeping ALU always granted with pointer forcing, or by filling both.
  - Required: mem_ready drops when count hits 2; a third beat is held on the input until ready returns, then accepted exactly once.
- **Zero register.** ALU sends addr=0 with data 0xFF.
  - Required: handshake completes, no wr_en, pend_mask bit 0 stays 0, busy stays 0.
- **Reset mid-flight.** Pulse rst_n low while both FIFOs hold 2 beats and wr_en=1.
  - Required: every output returns to its reset value immediately, and no write is issued after release.
